// File: rtl/lfa_adc_pkg.sv
// Shared types and constants for the LFA ADC128S022 reader.
// Optional 4-scan averaging is enabled by defining LFA_ADC_AVG_EN.
package lfa_adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } state_e;

  typedef enum logic [1:0] {
    IDX_L,
    IDX_M,
    IDX_R
  } ch_idx_e;

  localparam int FRAME_BITS      = 16;
  localparam int DATA_FIRST_EDGE = 5;
  localparam int AVG_SCANS       = 4;

  function automatic ch_idx_e next_idx(
    input ch_idx_e i
  );
    case (i)
      IDX_L:   return IDX_M;
      IDX_M:   return IDX_R;
      default: return IDX_L;
    endcase
  endfunction

endpackage

// File: rtl/lfa_adc_sclk_gen.sv
// SCLK half-period timer: idle-high clock level plus
// one-cycle rise/fall strobes issued the cycle before each edge.
module lfa_adc_sclk_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic hold_hi_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o,
  output logic tc_o
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;

  assign tc_o   = run_i && (cnt_q == CW'(CLK_DIV - 1));
  assign rise_o = tc_o && !sclk_q;
  assign fall_o = tc_o && sclk_q && !hold_hi_i;
  assign sclk_o = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!run_i) begin
      cnt_d  = '0;
      sclk_d = 1'b1;
    end else if (tc_o) begin
      cnt_d = '0;
      if (!hold_hi_i) sclk_d = !sclk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/lfa_adc_reader.sv
// Round-robin ADC128S022 reader publishing coherent L/M/R values.
// Define LFA_ADC_AVG_EN to publish 4-scan averages instead.
module lfa_adc_reader #(
  parameter int         CLK_DIV   = 16,
  parameter logic [2:0] CH_LEFT   = 3'd3,
  parameter logic [2:0] CH_MIDDLE = 3'd4,
  parameter logic [2:0] CH_RIGHT  = 3'd5
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        enable,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  output logic [11:0] left,
  output logic [11:0] middle,
  output logic [11:0] right,
  output logic        sample_valid
);

  import lfa_adc_pkg::*;

  state_e  state_q, state_d;
  ch_idx_e idx_q, idx_d;

  logic        run, hold_hi;
  logic        rise, fall, tc;
  logic        last_bit, to_idle;
  logic [2:0]  addr;
  logic [4:0]  rises_q, rises_d;
  logic        done_q, done_d;
  logic        din_q, din_d;
  logic        valid_q, valid_d;
  logic        prime_q, prime_d;
  logic [11:0] shift_q, shift_d;
  logic [11:0] shl_q, shl_d;
  logic [11:0] shm_q, shm_d;
  logic [11:0] left_q, left_d;
  logic [11:0] mid_q, mid_d;
  logic [11:0] right_q, right_d;

`ifdef LFA_ADC_AVG_EN
  logic [13:0] acc_l_q, acc_l_d;
  logic [13:0] acc_m_q, acc_m_d;
  logic [13:0] acc_r_q, acc_r_d;
  logic [13:0] sum_l, sum_m, sum_r;
  logic [1:0]  scan_q, scan_d;
`endif

  lfa_adc_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk (
    .clk_i    (clk_50M),
    .rst_i    (rst),
    .run_i    (run),
    .hold_hi_i(hold_hi),
    .sclk_o   (adc_sclk),
    .rise_o   (rise),
    .fall_o   (fall),
    .tc_o     (tc)
  );

  function automatic logic [2:0] ch_addr(
    input ch_idx_e i
  );
    case (i)
      IDX_L:   return CH_LEFT;
      IDX_M:   return CH_MIDDLE;
      default: return CH_RIGHT;
    endcase
  endfunction

  assign last_bit = (rises_q == 5'(FRAME_BITS));
  assign to_idle  = (state_q == GAP) && tc && !enable;
  // DIN addresses the channel whose data arrives next frame
  assign addr     = prime_q ? CH_LEFT
                            : ch_addr(next_idx(idx_q));

  always_ff @(posedge clk_50M) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = SETUP;
      SETUP:   if (tc) state_d = SHIFT;
      SHIFT:   if (tc && last_bit) state_d = GAP;
      default: if (tc) state_d = enable ? SETUP : IDLE;
    endcase
  end

  always_comb begin
    run      = (state_q != IDLE);
    hold_hi  = (state_q == GAP) ||
               ((state_q == SHIFT) && last_bit);
    adc_cs_n = (state_q == IDLE) || (state_q == GAP);
  end

  always_comb begin
    rises_d = '0;
    if (state_q == SHIFT)
      rises_d = rises_q + {4'b0, rise};
    done_d = rise && (rises_q == 5'(FRAME_BITS - 1));

    din_d = din_q;
    if (fall) begin
      unique case (1'b1)
        rises_q == 5'd2: din_d = addr[2];
        rises_q == 5'd3: din_d = addr[1];
        rises_q == 5'd4: din_d = addr[0];
        default:         din_d = 1'b0;
      endcase
    end

    shift_d = shift_q;
    if (rise && rises_q >= 5'(DATA_FIRST_EDGE - 1))
      shift_d = {shift_q[10:0], adc_dout};

    idx_d   = idx_q;
    prime_d = prime_q;
    shl_d   = shl_q;
    shm_d   = shm_q;
    left_d  = left_q;
    mid_d   = mid_q;
    right_d = right_q;
    valid_d = 1'b0;

`ifdef LFA_ADC_AVG_EN
    acc_l_d = acc_l_q;
    acc_m_d = acc_m_q;
    acc_r_d = acc_r_q;
    scan_d  = scan_q;
    sum_l   = acc_l_q + {2'b00, shl_q};
    sum_m   = acc_m_q + {2'b00, shm_q};
    sum_r   = acc_r_q + {2'b00, shift_q};
`endif

    if (done_q) begin
      if (prime_q) begin
        prime_d = 1'b0;
        idx_d   = IDX_L;
      end else begin
        idx_d = next_idx(idx_q);
        unique case (idx_q)
          IDX_L: shl_d = shift_q;
          IDX_M: shm_d = shift_q;
          default: begin
`ifdef LFA_ADC_AVG_EN
            if (scan_q == 2'(AVG_SCANS - 1)) begin
              left_d  = sum_l[13:2];
              mid_d   = sum_m[13:2];
              right_d = sum_r[13:2];
              valid_d = 1'b1;
              acc_l_d = '0;
              acc_m_d = '0;
              acc_r_d = '0;
              scan_d  = '0;
            end else begin
              acc_l_d = sum_l;
              acc_m_d = sum_m;
              acc_r_d = sum_r;
              scan_d  = scan_q + 2'd1;
            end
`else
            left_d  = shl_q;
            mid_d   = shm_q;
            right_d = shift_q;
            valid_d = 1'b1;
`endif
          end
        endcase
      end
    end

    if (to_idle) begin
      prime_d = 1'b1;
`ifdef LFA_ADC_AVG_EN
      acc_l_d = '0;
      acc_m_d = '0;
      acc_r_d = '0;
      scan_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      rises_q <= '0;
      done_q  <= 1'b0;
      din_q   <= 1'b0;
      shift_q <= '0;
      idx_q   <= IDX_L;
      prime_q <= 1'b1;
      shl_q   <= '0;
      shm_q   <= '0;
      left_q  <= '0;
      mid_q   <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
    end else begin
      rises_q <= rises_d;
      done_q  <= done_d;
      din_q   <= din_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      prime_q <= prime_d;
      shl_q   <= shl_d;
      shm_q   <= shm_d;
      left_q  <= left_d;
      mid_q   <= mid_d;
      right_q <= right_d;
      valid_q <= valid_d;
    end
  end

`ifdef LFA_ADC_AVG_EN
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      acc_l_q <= '0;
      acc_m_q <= '0;
      acc_r_q <= '0;
      scan_q  <= '0;
    end else begin
      acc_l_q <= acc_l_d;
      acc_m_q <= acc_m_d;
      acc_r_q <= acc_r_d;
      scan_q  <= scan_d;
    end
  end
`endif

  assign adc_din      = din_q;
  assign left         = left_q;
  assign middle       = mid_q;
  assign right        = right_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_lfa_adc_reader.sv
// Bench for lfa_adc_reader: ADC128S022 model, scoreboard
// of published triples, and timing/sequence checks.
module tb_lfa_adc_reader;

  localparam int CLK_DIV = 16;
  localparam int FRAME   = 34 * CLK_DIV;
`ifdef LFA_ADC_AVG_EN
  localparam int SCANS = 4;
`else
  localparam int SCANS = 1;
`endif
  localparam int PERIOD = 3 * FRAME * SCANS;
  localparam int NV     = 5;

  localparam int K_CSF = 0;
  localparam int K_CSR = 1;
  localparam int K_SCR = 2;
  localparam int K_VAL = 3;

  logic        clk_50M = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        adc_dout = 1'b0;
  logic        adc_cs_n, adc_sclk, adc_din;
  logic        sample_valid;
  logic [11:0] left, middle, right;

  lfa_adc_reader #(
    .CLK_DIV  (CLK_DIV),
    .CH_LEFT  (3'd3),
    .CH_MIDDLE(3'd4),
    .CH_RIGHT (3'd5)
  ) dut (
    .clk_50M     (clk_50M),
    .rst         (rst),
    .enable      (enable),
    .adc_dout    (adc_dout),
    .adc_cs_n    (adc_cs_n),
    .adc_sclk    (adc_sclk),
    .adc_din     (adc_din),
    .left        (left),
    .middle      (middle),
    .right       (right),
    .sample_valid(sample_valid)
  );

  always #10 clk_50M = ~clk_50M;

  typedef struct {
    logic [11:0] l, m, r;
  } trip_t;

  typedef struct {
    logic [11:0] l_in, m_in, r_in;
    logic [11:0] l_exp, m_exp, r_exp;
  } vec_t;

  trip_t sb[$];
  vec_t  tbl[NV];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;

  always @(posedge clk_50M) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  // ADC128S022 model: DIN on rises 3..5, data on rises 5..16
  logic [11:0] vals[8];
  logic [11:0] cur_word;
  logic [11:0] next_word = 12'hA5C;
  logic [2:0]  addr_sr = '0;
  int          rcnt = 0;
  int          addr_log[$];
  int          rise_log[$];
  bit          alt_mode = 0;
  bit          alt = 0;

  always @(negedge adc_cs_n) begin
    rcnt     = 0;
    addr_sr  = '0;
    cur_word = next_word;
  end

  always @(posedge adc_sclk) begin
    if (adc_cs_n === 1'b0) begin
      rcnt++;
      if (rcnt >= 3 && rcnt <= 5)
        addr_sr = {addr_sr[1:0], adc_din};
    end
  end

  always @(negedge adc_sclk) begin
    int k;
    if (adc_cs_n === 1'b0) begin
      k = rcnt + 1;
      adc_dout = (k >= 5 && k <= 16) ?
                 cur_word[16-k] : 1'b0;
    end
  end

  always @(posedge adc_cs_n) begin
    if (rst === 1'b0) begin
      addr_log.push_back(int'(addr_sr));
      rise_log.push_back(rcnt);
      if (alt_mode && addr_sr == 3'd3) begin
        next_word = alt ? 12'd1003 : 12'd1000;
        alt = !alt;
      end else begin
        next_word = vals[addr_sr];
      end
    end
  end

  logic sclk_p = 1'b1;
  logic din_p = 1'b0;
  logic cs_p = 1'b1;
  logic valid_p = 1'b0;
  int   last_rise = 0;
  int   din_bad = 0;
  int   cs_falls = 0;

  always @(negedge clk_50M) begin
    trip_t t;
    if (adc_sclk === 1'b1 && sclk_p === 1'b0)
      last_rise = cyc;
    if (adc_din !== din_p &&
        !(sclk_p === 1'b1 && adc_sclk === 1'b0))
      din_bad++;
    if (cs_p === 1'b1 && adc_cs_n === 1'b0)
      cs_falls++;
    if (valid_p === 1'b1)
      check("valid_width", {31'b0, sample_valid}, 0);
    if (sample_valid === 1'b1) begin
      check("valid_after_rise16", cyc - last_rise, 1);
      check("rises_at_valid", rcnt, 16);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got 1 want 0");
      end else begin
        t = sb.pop_front();
        check("left", {20'b0, left}, {20'b0, t.l});
        check("middle", {20'b0, middle}, {20'b0, t.m});
        check("right", {20'b0, right}, {20'b0, t.r});
      end
    end
    sclk_p  = adc_sclk;
    din_p   = adc_din;
    cs_p    = adc_cs_n;
    valid_p = sample_valid;
  end

  function automatic logic sig(input int kind);
    case (kind)
      K_CSF, K_CSR: return adc_cs_n;
      K_SCR:        return adc_sclk;
      default:      return sample_valid;
    endcase
  endfunction

  task automatic wait_for(input int kind,
                          input int budget,
                          input string name);
    logic p, c;
    p = sig(kind);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk_50M);
      c = sig(kind);
      if (kind == K_CSF) begin
        if (p === 1'b1 && c === 1'b0) return;
      end else if (p === 1'b0 && c === 1'b1) begin
        return;
      end
      p = c;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL timeout_%s: got none want event", name);
  endtask

  task automatic check_window(input string name,
                              input int d);
    check(name, {31'b0,
          (d >= 3 * SCANS * FRAME) &&
          (d < (3 * SCANS + 1) * FRAME)}, 1);
  endtask

  int t0, t1, nf;
  int seq3[3] = '{3, 4, 5};

  initial begin
    tbl[0] = '{12'h000, 12'hFFF, 12'h800,
               12'h000, 12'hFFF, 12'h800};
    tbl[1] = '{12'h555, 12'hAAA, 12'h001,
               12'h555, 12'hAAA, 12'h001};
    tbl[2] = '{12'hFFF, 12'h000, 12'h7FF,
               12'hFFF, 12'h000, 12'h7FF};
    tbl[3] = '{12'h123, 12'h456, 12'h789,
               12'h123, 12'h456, 12'h789};
    tbl[4] = '{12'h001, 12'h800, 12'hFFE,
               12'h001, 12'h800, 12'hFFE};
    for (int i = 0; i < 8; i++) vals[i] = 12'hF0F;
    vals[3] = 12'h3E8;
    vals[4] = 12'hBB8;
    vals[5] = 12'h0C8;

    rst    = 1'b1;
    enable = 1'b1;
    repeat (5) @(posedge clk_50M);
    @(negedge clk_50M);
    check("rst_cs_n", {31'b0, adc_cs_n}, 1);
    check("rst_sclk", {31'b0, adc_sclk}, 1);
    check("rst_din", {31'b0, adc_din}, 0);
    check("rst_left", {20'b0, left}, 0);
    check("rst_middle", {20'b0, middle}, 0);
    check("rst_right", {20'b0, right}, 0);
    check("rst_valid", {31'b0, sample_valid}, 0);

    addr_log.delete();
    rise_log.delete();
    rst = 1'b0;
    t0  = cyc;
    wait_for(K_CSF, 4, "cs_fall");
    check("cs_fall_latency", cyc - t0, 1);
    t0 = cyc;

    repeat (2) sb.push_back('{12'h3E8, 12'hBB8, 12'h0C8});
    wait_for(K_VAL, (3 * SCANS + 2) * FRAME, "first_valid");
    t1 = cyc;
    check_window("first_valid_frame", t1 - t0);
    wait_for(K_VAL, PERIOD + FRAME, "second_valid");
    check("valid_period", cyc - t1, PERIOD);

    check("addr_log_size", {31'b0, addr_log.size() >= 6}, 1);
    for (int i = 0; i < 6 && i < addr_log.size(); i++) begin
      check($sformatf("addr_seq%0d", i),
            addr_log[i], seq3[i % 3]);
      check($sformatf("rises%0d", i), rise_log[i], 16);
    end

    // reset at rise 8 of the next R frame
    repeat (3) wait_for(K_CSF, 2 * FRAME, "to_r_frame");
    repeat (8) wait_for(K_SCR, 3 * CLK_DIV, "to_rise8");
    rst = 1'b1;
    @(negedge clk_50M);
    @(negedge clk_50M);
    check("mid_rst_cs_n", {31'b0, adc_cs_n}, 1);
    check("mid_rst_sclk", {31'b0, adc_sclk}, 1);
    check("mid_rst_left", {20'b0, left}, 0);
    check("mid_rst_middle", {20'b0, middle}, 0);
    check("mid_rst_right", {20'b0, right}, 0);
    check("mid_rst_valid", {31'b0, sample_valid}, 0);
    addr_log.delete();
    rise_log.delete();
    rst = 1'b0;
    wait_for(K_CSF, 4, "cs_fall_after_mid_rst");
    t0 = cyc;
    sb.push_back('{12'h3E8, 12'hBB8, 12'h0C8});
    wait_for(K_VAL, (3 * SCANS + 2) * FRAME, "valid_after_rst");
    check_window("rst_valid_frame", cyc - t0);
    check("prime_addr_size", {31'b0, addr_log.size() > 0}, 1);
    if (addr_log.size() > 0)
      check("prime_addr", addr_log[0], 3);

    // drop enable in the middle of the next frame
    wait_for(K_CSF, 2 * FRAME, "drop_frame");
    repeat (4) wait_for(K_SCR, 3 * CLK_DIV, "drop_rise4");
    enable = 1'b0;
    wait_for(K_CSR, FRAME, "drop_frame_end");
    check("drop_log_size", {31'b0, rise_log.size() > 0}, 1);
    if (rise_log.size() > 0)
      check("drop_frame_rises",
            rise_log[rise_log.size()-1], 16);
    nf = cs_falls;
    repeat (2 * FRAME) @(negedge clk_50M);
    check("idle_no_frames", cs_falls - nf, 0);
    check("idle_cs_n", {31'b0, adc_cs_n}, 1);
    check("idle_sclk", {31'b0, adc_sclk}, 1);
    check("idle_left", {20'b0, left}, 32'h3E8);
    check("idle_middle", {20'b0, middle}, 32'hBB8);
    check("idle_right", {20'b0, right}, 32'h0C8);

    for (int i = 0; i < NV; i++) begin
      vals[3] = tbl[i].l_in;
      vals[4] = tbl[i].m_in;
      vals[5] = tbl[i].r_in;
      sb.push_back('{tbl[i].l_exp, tbl[i].m_exp,
                     tbl[i].r_exp});
      enable = 1'b1;
      wait_for(K_CSF, 4, "vec_start");
      t0 = cyc;
      wait_for(K_VAL, (3 * SCANS + 2) * FRAME, "vec_valid");
      check_window($sformatf("vec%0d_latency", i), cyc - t0);
      enable = 1'b0;
      wait_for(K_CSR, FRAME, "vec_end");
      repeat (2 * CLK_DIV) @(negedge clk_50M);
    end

`ifdef LFA_ADC_AVG_EN
    alt_mode = 1;
    alt      = 0;
    vals[4]  = 12'd2000;
    vals[5]  = 12'd3000;
    sb.push_back('{12'd1001, 12'd2000, 12'd3000});
    enable = 1'b1;
    wait_for(K_VAL, (3 * SCANS + 2) * FRAME, "avg_valid");
    enable = 1'b0;
    wait_for(K_CSR, FRAME, "avg_end");
    repeat (2 * CLK_DIV) @(negedge clk_50M);
`endif

    check("din_only_on_sclk_fall", din_bad, 0);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
